win_checker: RTL and testbench
==============================

# win_checker

Downstream consumer of the board manager's `board` array in the Connect Four game. On a `start` pulse, normally issued the cycle after an `insert_en`, it snapshots the 6×7 board and scans it one cell per clock for four-in-a-row. It then reports one of three results (winner, draw, or no result) plus the location and direction of the winning line for display highlighting. The result is held stable until the next `start`.

## Interface
- `ROWS`, default 6: board rows; row 0 is the top row and pieces settle toward row 5.
- `COLS`, default 7: board columns.
- `clk` in, 1: system clock; the block has one clock domain.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: request a scan; sampled only in IDLE.
- `board` in, 2 × [0:ROWS-1][0:COLS-1]: cell codes 0 = empty, 1 = player 1, 2 = player 2, 3 = invalid.
- `busy` out, 1: high while in SCAN.
- `done` out, 1: one-cycle pulse when the result registers update.
- `winner` out, 2: 0 = none, 1 or 2 = winning player.
- `draw` out, 1: board is full and there is no winner.
- `win_row` out, 3: row of the anchor cell of the winning line.
- `win_col` out, 3: column of the anchor cell of the winning line.
- `win_dir` out, 2: direction of the winning line; 0 = horizontal right, 1 = vertical down, 2 = diagonal down-right, 3 = diagonal down-left.

## Operation
- FSM states:
  - IDLE: `start` → SCAN.
  - SCAN: hit, or last cell evaluated → DONE.
  - DONE: unconditional → IDLE.
- On accepting `start`:
  - load an internal snapshot of `board`;
  - set cell index `idx` = 0;
  - clear `winner`, `draw`, `win_*`.
  - All evaluation uses the snapshot only; `board` may change during SCAN.
- Scan order: row-major, `idx = row*COLS + col`, from 0 to 41. In each SCAN cycle the anchor cell at `idx` is checked combinationally in four directions.
- Bounds for each direction:
  - horizontal: col ≤ 3;
  - vertical: row ≤ 2;
  - diagonal down-right: row ≤ 2 and col ≤ 3;
  - diagonal down-left: row ≤ 2 and col ≥ 3.
  - Directions outside these bounds are never evaluated, so there is no wrap-around.
- Match rule: all 4 cells are equal and the anchor code is 1 or 2. Codes 0 and 3 never match.
- Priority: the first hit in scan order wins. Within one cell the priority is dir 0 > 1 > 2 > 3. The scan terminates early on the first hit.
- Hit at `idx` k:
  - `winner` = anchor code;
  - `win_row` / `win_col` = coordinates of cell k;
  - `win_dir` = matching direction;
  - `draw` = 0.
- No hit after `idx` 41: `winner` = 0, and `draw` = 1 iff every row-0 cell of the snapshot is non-zero. Code 3 counts as occupied.
- `start` while in SCAN or DONE is ignored and is not queued.
- Reset values: all outputs 0, state IDLE, `idx` 0, snapshot all 0.

## Timing
- Edge E0 accepts `start`. A hit at `idx` k registers at edge E(k+1).
- `done` and the new result are visible in the cycle after E(k+1). State returns to IDLE at E(k+2).
- No-win latency: result registers at E42 and `done` is high in the cycle after E42.
- `busy` is high from after E0 until the result edge, and low in DONE and IDLE.
- A new `start` is accepted no earlier than the cycle after DONE.
- `rst` mid-scan aborts the scan at the next edge: all outputs return to 0 and no `done` pulse is produced.
- `start` asserted in the same cycle as `rst`: `rst` wins.
- Result outputs hold their value until the next accepted `start` or `rst`.

## Structure
- Shared package `connect4_pkg` holds:
  - `ROWS` / `COLS` constants;
  - `cell_t` enum (EMPTY, P1, P2, INVALID);
  - `dir_t` enum (H, V, DR, DL).
  - `Board_Manager` will be migrated to the same package.
- Sub-module `line_match`: combinational, takes 4 cell codes and outputs `match` plus the player. It is instantiated four times, once per direction.
- Cell gathering is a mux driven by row/col counters; keep separate row and col counters rather than dividing `idx`.

## Test plan
- Empty board, `start` → `done` in the cycle after E42; `winner` = 0, `draw` = 0.
- Player 1 in col 3, rows 2–5 → hit at `idx` 17, `done` after E18; `winner` = 1, `win_row` = 2, `win_col` = 3, `win_dir` = 1.
- Player 2 in row 5, cols 0–3 → hit at `idx` 35, `done` after E36; `winner` = 2, `win_row` = 5, `win_col` = 0, `win_dir` = 0.
- Diagonal down-left, player 1 at (2,6), (3,5), (4,4), (5,3) → `winner` = 1, `win_row` = 2, `win_col` = 6, `win_dir` = 3. Repeat with one cell set to code 3 → `winner` = 0.
- Full board with no line → `winner` = 0, `draw` = 1. Change `board` mid-scan → result is unchanged (snapshot is used).
- `start` repeated during SCAN → ignored, exactly one `done`. Assert `rst` at E10 of a scan → all outputs 0, no `done`, next `start` is accepted normally.

Source files
------------

// File: rtl/connect4_pkg.sv
// -----------------------------------------------------------------------------
// connect4_pkg
// Shared definitions for the Connect Four blocks: board dimensions, the
// two-bit cell code and the four line directions used when reporting a win.
// No ports (package).
// -----------------------------------------------------------------------------
package connect4_pkg;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  // Cell codes as stored in the board array
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    P1      = 2'd1,
    P2      = 2'd2,
    INVALID = 2'd3
  } cell_t;

  // Direction of a four-in-a-row line, measured from its anchor cell
  typedef enum logic [1:0] {
    H  = 2'd0,  // horizontal, to the right
    V  = 2'd1,  // vertical, downward
    DR = 2'd2,  // diagonal down-right
    DL = 2'd3   // diagonal down-left
  } dir_t;

endpackage

// File: rtl/line_match.sv
// -----------------------------------------------------------------------------
// line_match
// Combinational check of four cell codes for a four-in-a-row line.
// Ports:
//   c0..c3  in  [1:0]  cell codes, c0 is the anchor cell
//   match   out        all four equal and owned by player 1 or 2
//   player  out [1:0]  winning player code when match, otherwise 0
// -----------------------------------------------------------------------------
module line_match
  import connect4_pkg::*;
(
  input  logic [1:0] c0,
  input  logic [1:0] c1,
  input  logic [1:0] c2,
  input  logic [1:0] c3,
  output logic       match,
  output logic [1:0] player
);

  logic anchor_is_player;

  // Empty and invalid cells can never form a line, even four in a row
  assign anchor_is_player = (c0 == P1) || (c0 == P2);

  assign match  = anchor_is_player && (c1 == c0) && (c2 == c0) && (c3 == c0);
  assign player = match ? c0 : 2'd0;

endmodule

// File: rtl/win_checker.sv
// -----------------------------------------------------------------------------
// win_checker
// Snapshots the Connect Four board on start and scans it one anchor cell per
// clock in row-major order, looking for four-in-a-row in four directions.
// Reports the winner (or a draw) together with the anchor cell and direction
// of the winning line. Results hold until the next accepted start or reset.
// Ports:
//   clk      in          system clock
//   rst      in          synchronous active-high reset
//   start    in          scan request, only honoured while idle
//   board    in  [r][c]  2-bit cell codes, row 0 is the top row
//   busy     out         high while scanning
//   done     out         one-cycle pulse when the result registers update
//   winner   out [1:0]   0 = none, 1/2 = winning player
//   draw     out         board full with no winner
//   win_row  out [2:0]   anchor row of the winning line
//   win_col  out [2:0]   anchor column of the winning line
//   win_dir  out [1:0]   direction of the winning line (dir_t encoding)
// -----------------------------------------------------------------------------
module win_checker
  import connect4_pkg::*;
#(
  parameter int ROWS = connect4_pkg::ROWS,
  parameter int COLS = connect4_pkg::COLS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [0:ROWS-1][0:COLS-1][1:0]   board,
  output logic                             busy,
  output logic                             done,
  output logic [1:0]                       winner,
  output logic                             draw,
  output logic [2:0]                       win_row,
  output logic [2:0]                       win_col,
  output logic [1:0]                       win_dir
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);
  // Highest anchor row/col that still leaves room for three more cells
  localparam logic [2:0] ROW_LIM  = 3'(ROWS - 4);
  localparam logic [2:0] COL_LIM  = 3'(COLS - 4);
  // Lowest anchor column for a down-left line
  localparam logic [2:0] DL_MIN   = 3'd3;

  state_t                           state_q, state_d;
  logic [0:ROWS-1][0:COLS-1][1:0]   snap;
  logic [2:0]                       row_q, col_q;

  logic [1:0] h_cells  [4];
  logic [1:0] v_cells  [4];
  logic [1:0] dr_cells [4];
  logic [1:0] dl_cells [4];

  logic       h_match, v_match, dr_match, dl_match;
  logic [1:0] h_player, v_player, dr_player, dl_player;
  logic       h_ok, v_ok, dr_ok, dl_ok;

  logic       hit;
  logic [1:0] hit_player;
  logic [1:0] hit_dir;
  logic       last_cell;
  logic       board_full;

  // Coordinates outside the board read as empty so they can never match
  function automatic logic [1:0] cell_at(input logic [2:0] r, input logic [2:0] c);
    if (r <= LAST_ROW && c <= LAST_COL) begin
      cell_at = snap[r][c];
    end else begin
      cell_at = EMPTY;
    end
  endfunction

  // Gather the four cells of each candidate line from the snapshot. Offsets
  // wrap in 3 bits, but a wrapped line is always gated off by the bounds.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      h_cells[i]  = cell_at(row_q,          col_q + 3'(i));
      v_cells[i]  = cell_at(row_q + 3'(i),  col_q);
      dr_cells[i] = cell_at(row_q + 3'(i),  col_q + 3'(i));
      dl_cells[i] = cell_at(row_q + 3'(i),  col_q - 3'(i));
    end
  end

  line_match u_match_h (
    .c0(h_cells[0]), .c1(h_cells[1]), .c2(h_cells[2]), .c3(h_cells[3]),
    .match(h_match), .player(h_player)
  );

  line_match u_match_v (
    .c0(v_cells[0]), .c1(v_cells[1]), .c2(v_cells[2]), .c3(v_cells[3]),
    .match(v_match), .player(v_player)
  );

  line_match u_match_dr (
    .c0(dr_cells[0]), .c1(dr_cells[1]), .c2(dr_cells[2]), .c3(dr_cells[3]),
    .match(dr_match), .player(dr_player)
  );

  line_match u_match_dl (
    .c0(dl_cells[0]), .c1(dl_cells[1]), .c2(dl_cells[2]), .c3(dl_cells[3]),
    .match(dl_match), .player(dl_player)
  );

  // A direction is only considered when the whole line fits on the board
  assign h_ok  = (col_q <= COL_LIM);
  assign v_ok  = (row_q <= ROW_LIM);
  assign dr_ok = (row_q <= ROW_LIM) && (col_q <= COL_LIM);
  assign dl_ok = (row_q <= ROW_LIM) && (col_q >= DL_MIN);

  // Within one anchor cell, lower direction codes take priority
  always_comb begin
    hit        = 1'b0;
    hit_player = 2'd0;
    hit_dir    = H;
    if (h_ok && h_match) begin
      hit        = 1'b1;
      hit_player = h_player;
      hit_dir    = H;
    end else if (v_ok && v_match) begin
      hit        = 1'b1;
      hit_player = v_player;
      hit_dir    = V;
    end else if (dr_ok && dr_match) begin
      hit        = 1'b1;
      hit_player = dr_player;
      hit_dir    = DR;
    end else if (dl_ok && dl_match) begin
      hit        = 1'b1;
      hit_player = dl_player;
      hit_dir    = DL;
    end
  end

  // Pieces settle downward, so a full top row means a full board; code 3
  // counts as occupied
  always_comb begin
    board_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (snap[0][c] == EMPTY) begin
        board_full = 1'b0;
      end
    end
  end

  assign last_cell = (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (hit || last_cell) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Snapshot, scan counters and result registers. Results are cleared when
  // a scan is accepted and written exactly once when the scan ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      winner  <= '0;
      draw    <= 1'b0;
      win_row <= '0;
      win_col <= '0;
      win_dir <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            snap    <= board;
            row_q   <= '0;
            col_q   <= '0;
            winner  <= '0;
            draw    <= 1'b0;
            win_row <= '0;
            win_col <= '0;
            win_dir <= '0;
          end
        end
        SCAN: begin
          if (hit) begin
            winner  <= hit_player;
            draw    <= 1'b0;
            win_row <= row_q;
            win_col <= col_q;
            win_dir <= hit_dir;
          end else if (last_cell) begin
            winner  <= '0;
            draw    <= board_full;
          end else if (col_q == LAST_COL) begin
            col_q <= '0;
            row_q <= row_q + 3'd1;
          end else begin
            col_q <= col_q + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_win_checker.sv
// -----------------------------------------------------------------------------
// tb_win_checker
// Directed-vector bench for win_checker. Each scan request pushes its
// hand-computed result onto a queue; a monitor pops and compares whenever
// the DUT pulses done, including the cycle at which done appears.
// -----------------------------------------------------------------------------
module tb_win_checker;
  import connect4_pkg::*;

  typedef logic [0:5][0:6][1:0] board_t;

  typedef struct {
    string name;
    int    winner;
    int    draw;
    int    row;
    int    col;
    int    dir;
    int    lat;
    int    done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  board_t     board;
  logic       busy;
  logic       done;
  logic [1:0] winner;
  logic       draw;
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic [1:0] win_dir;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  win_checker dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .board  (board),
    .busy   (busy),
    .done   (done),
    .winner (winner),
    .draw   (draw),
    .win_row(win_row),
    .win_col(win_col),
    .win_dir(win_dir)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic exp_t mkExp(input string name, input int w, input int d,
                                 input int r, input int c, input int dir, input int lat);
    exp_t e;
    e.name     = name;
    e.winner   = w;
    e.draw     = d;
    e.row      = r;
    e.col      = c;
    e.dir      = dir;
    e.lat      = lat;
    e.done_cyc = 0;
    return e;
  endfunction

  // Alternating pairs across columns, alternating rows: full, no four-in-a-row
  function automatic board_t fullNoLine();
    board_t b;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        b[r][c] = 2'(1 + ((c / 2 + r) % 2));
      end
    end
    return b;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      checkOutput("done_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_winner"},  int'(winner),  e.winner);
        checkOutput({e.name, "_draw"},    int'(draw),    e.draw);
        checkOutput({e.name, "_win_row"}, int'(win_row), e.row);
        checkOutput({e.name, "_win_col"}, int'(win_col), e.col);
        checkOutput({e.name, "_win_dir"}, int'(win_dir), e.dir);
        checkOutput({e.name, "_latency"}, cyc,           e.done_cyc);
        checkOutput({e.name, "_busy_in_done"}, int'(busy), 0);
      end
    end
  end

  // Issue one start pulse; the expected done cycle is relative to the
  // accepting edge. Returns at the first falling edge of the scan.
  task automatic applyStimulus(input board_t b, input exp_t e);
    @(negedge clk);
    board = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.done_cyc = cyc + e.lat;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitResult();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkOutput("result_timeout", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    board_t b;

    rst   = 1'b1;
    start = 1'b0;
    board = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",    int'(busy),    0);
    checkOutput("reset_done",    int'(done),    0);
    checkOutput("reset_winner",  int'(winner),  0);
    checkOutput("reset_draw",    int'(draw),    0);
    checkOutput("reset_win_row", int'(win_row), 0);
    checkOutput("reset_win_col", int'(win_col), 0);
    checkOutput("reset_win_dir", int'(win_dir), 0);
    rst = 1'b0;

    $display("[TB] empty board");
    applyStimulus('0, mkExp("empty", 0, 0, 0, 0, 0, 42));
    checkOutput("empty_busy_scan", int'(busy), 1);
    waitResult();

    $display("[TB] vertical player 1");
    b = '0;
    for (int r = 2; r < 6; r++) b[r][3] = 2'd1;
    applyStimulus(b, mkExp("vert", 1, 0, 2, 3, 1, 18));
    waitResult();

    $display("[TB] horizontal player 2");
    b = '0;
    for (int c = 0; c < 4; c++) b[5][c] = 2'd2;
    applyStimulus(b, mkExp("horiz", 2, 0, 5, 0, 0, 36));
    checkOutput("horiz_busy_scan", int'(busy), 1);
    waitResult();

    $display("[TB] diagonal down-left");
    b = '0;
    b[2][6] = 2'd1;
    b[3][5] = 2'd1;
    b[4][4] = 2'd1;
    b[5][3] = 2'd1;
    applyStimulus(b, mkExp("diag_dl", 1, 0, 2, 6, 3, 21));
    waitResult();
    repeat (3) @(negedge clk);
    checkOutput("diag_dl_hold_winner",  int'(winner),  1);
    checkOutput("diag_dl_hold_win_dir", int'(win_dir), 3);
    checkOutput("diag_dl_hold_busy",    int'(busy),    0);

    $display("[TB] diagonal with invalid cell");
    b[4][4] = 2'd3;
    applyStimulus(b, mkExp("diag_invalid", 0, 0, 0, 0, 0, 42));
    waitResult();

    $display("[TB] full board, board changes and extra starts mid-scan");
    applyStimulus(fullNoLine(), mkExp("full_draw", 0, 1, 0, 0, 0, 42));
    repeat (5) @(negedge clk);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        board[r][c] = 2'd1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waitResult();
    repeat (3) @(negedge clk);
    checkOutput("full_draw_hold_draw", int'(draw), 1);
    checkOutput("full_draw_idle_busy", int'(busy), 0);

    $display("[TB] start during DONE");
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        b[r][c] = 2'd1;
      end
    end
    applyStimulus(b, mkExp("all_p1", 1, 0, 0, 0, 0, 1));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_in_done_ignored", int'(busy), 0);
    waitResult();
    checkOutput("all_p1_hold_winner", int'(winner), 1);

    $display("[TB] reset mid-scan");
    b = '0;
    for (int r = 2; r < 6; r++) b[r][3] = 2'd2;
    applyStimulus(b, mkExp("aborted", 2, 0, 2, 3, 1, 18));
    repeat (9) @(negedge clk);
    checkOutput("abort_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy",   int'(busy),   0);
    checkOutput("abort_done",   int'(done),   0);
    checkOutput("abort_winner", int'(winner), 0);
    repeat (20) @(negedge clk);
    checkOutput("abort_idle_busy", int'(busy), 0);

    b = '0;
    for (int c = 0; c < 4; c++) b[5][c] = 2'd2;
    applyStimulus(b, mkExp("after_abort", 2, 0, 5, 0, 0, 36));
    waitResult();

    $display("[TB] reset together with start");
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    board = fullNoLine();
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    checkOutput("rst_beats_start_busy",    int'(busy),    0);
    checkOutput("rst_beats_start_winner",  int'(winner),  0);
    checkOutput("rst_beats_start_win_row", int'(win_row), 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_beats_start_idle", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
